gpi_debounce: RTL and testbench

- Conditions raw board inputs (slide switches, push buttons) before they reach the demo system's general-purpose input port.
- Per bit: multi-flop synchroniser, then a stability counter. Produces a clean level, plus one-cycle rise/fall pulses and a combined change strobe.
- Sits between the FPGA top-level pins and the demo system's gp_i. Runs in the system clock domain from the clock generator.

---
 rtl/gpi_debounce.sv | 101 ++++++++++
 tb/tb_gpi_debounce.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gpi_debounce.sv
// Input conditioner for board switches and buttons: each bit is synchronised, then
// accepted only after the new level has held steady for DebounceCycles clocks.
module gpi_debounce #(
  parameter int Width          = 20,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 500000,
  parameter int CntW           = $clog2(DebounceCycles + 1)
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [Width-1:0] sync_q [SyncStages];
  logic [Width-1:0] sync_d [SyncStages];
  logic [Width-1:0] sync_s;

  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];
  logic [Width-1:0] gp_q, gp_d;
  logic [Width-1:0] rise_q, rise_d;
  logic [Width-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  // Plain flop chain: nothing may sit between stages or metastability settling suffers.
  always_comb begin
    sync_d[0] = gp_raw_i;
    for (int j = 1; j < SyncStages; j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      for (int j = 0; j < SyncStages; j++) begin
        sync_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < SyncStages; j++) begin
        sync_q[j] <= sync_d[j];
      end
    end
  end

  // Counter only runs while the synchronised level disagrees with the accepted one,
  // so it is cleared on any match and can never exceed CntLast.
  always_comb begin
    gp_d   = gp_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < Width; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_s[i] == gp_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        gp_d[i]   = sync_s[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_s[i];
        fall_d[i] = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= '0;
      end
      gp_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      gp_q      <= gp_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign gp_o      = gp_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_gpi_debounce.sv
// Scoreboard bench for gpi_debounce: a window-based reference model predicts every
// cycle's outputs; a monitor compares them one cycle at a time.
module tb_gpi_debounce;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk_sys_i = 1'b0;
  logic         rst_sys_i = 1'b1;
  logic [W-1:0] gp_raw_i  = '0;
  logic [W-1:0] gp_o, rise_o, fall_o;
  logic         changed_o;

  gpi_debounce #(
    .Width(W), .SyncStages(S), .DebounceCycles(D)
  ) dut (
    .clk_sys_i(clk_sys_i),
    .rst_sys_i(rst_sys_i),
    .gp_raw_i (gp_raw_i),
    .gp_o     (gp_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the level seen by the filter at post-reset edge n is the raw
  // value sampled S edges earlier. A bit is accepted at edge n when the last D
  // filter samples all differ from the accepted level and all lie after its
  // previous acceptance.
  logic [W-1:0]      raw_hist [$];
  logic [W-1:0]      s_hist   [$];
  logic [3*W:0]      exp_q    [$];
  int                m_n;
  logic [W-1:0]      m_gp;
  int                last_acc [W];
  logic [W-1:0]      m_s, m_acc;
  bit                m_ok;

  always @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      raw_hist.delete();
      s_hist.delete();
      m_n  = 0;
      m_gp = '0;
      for (int i = 0; i < W; i++) last_acc[i] = -1;
      exp_q.push_back('0);
    end else begin
      m_s = (m_n >= S) ? raw_hist[m_n-S] : '0;
      raw_hist.push_back(gp_raw_i);
      s_hist.push_back(m_s);
      m_acc = '0;
      for (int i = 0; i < W; i++) begin
        if (m_n - D + 1 > last_acc[i]) begin
          m_ok = 1'b1;
          for (int j = m_n - D + 1; j <= m_n; j++) begin
            if (s_hist[j][i] == m_gp[i]) m_ok = 1'b0;
          end
          if (m_ok) begin
            m_acc[i]    = 1'b1;
            last_acc[i] = m_n;
          end
        end
      end
      exp_q.push_back({m_gp ^ m_acc, m_acc & ~m_gp, m_acc & m_gp, |m_acc});
      m_gp = m_gp ^ m_acc;
      m_n++;
    end
  end

  // Monitor: outputs are presented every cycle, compared just after the edge.
  logic [3*W:0] exp_v, got_v;
  always @(posedge clk_sys_i) begin
    #1;
    got_v = {gp_o, rise_o, fall_o, changed_o};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty t=%0t got=%b required an expected entry", $time, got_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (got_v === exp_v) n_pass++;
      else $display("FAIL cycle_outputs t=%0t got gp=%b rise=%b fall=%b chg=%b required gp=%b rise=%b fall=%b chg=%b",
                    $time, got_v[3*W:2*W+1], got_v[2*W:W+1], got_v[W:1], got_v[0],
                    exp_v[3*W:2*W+1], exp_v[2*W:W+1], exp_v[W:1], exp_v[0]);
    end
  end

  task automatic hold(input logic [W-1:0] v, input int n);
    gp_raw_i = v;
    repeat (n) @(negedge clk_sys_i);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({gp_o, rise_o, fall_o, changed_o} === '0) n_pass++;
    else $display("FAIL %s t=%0t got gp=%b rise=%b fall=%b chg=%b required all zero",
                  name, $time, gp_o, rise_o, fall_o, changed_o);
  endtask

  task automatic do_reset(input int n);
    rst_sys_i = 1'b1;
    #1;
    check_zero("reset_immediate");
    @(negedge clk_sys_i);
    repeat (n) @(negedge clk_sys_i);
    rst_sys_i = 1'b0;
  endtask

  logic [W-1:0] rv;

  initial begin
    @(negedge clk_sys_i);
    check_zero("reset_state");
    @(negedge clk_sys_i);
    rst_sys_i = 1'b0;

    // Single rise on bit0
    hold(4'b0000, 10);
    hold(4'b0001, 10);
    // Bit1 high, short low glitch, high again
    hold(4'b0011, 10);
    hold(4'b0001, 3);
    hold(4'b0011, 10);
    // Bit2 toggling every 2 cycles, then settled high
    for (int k = 0; k < 20; k++) hold({1'b0, k[0], 2'b11}, 2);
    hold(4'b0111, 12);
    // Simultaneous rise on bits 0 and 3
    hold(4'b0000, 12);
    hold(4'b1001, 12);
    // Bit3 drop and hold
    hold(4'b0001, 12);
    // Glitch one cycle before acceptance
    hold(4'b0000, 12);
    hold(4'b0100, 3);
    hold(4'b0000, 1);
    hold(4'b0100, 12);
    // Reset mid-count with all inputs high, then held through release
    hold(4'b0000, 12);
    hold(4'b1111, 4);
    do_reset(2);
    hold(4'b1111, 12);

    // Randomized holds of varying length, with occasional resets
    for (int it = 0; it < 400; it++) begin
      rv = 4'($urandom_range(0, 15));
      hold(rv, $urandom_range(1, 2 * D + 2));
      if ($urandom_range(0, 60) == 0) do_reset($urandom_range(0, 2));
    end
    hold(gp_raw_i, 12);

    @(posedge clk_sys_i);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
